// File: rtl/mem_port_arbiter_if.sv
// Requester-side bundle of the program/data RAM arbiter: three request ports
// plus the shared grant, read-return and starvation status signals.
// Ports: req/we/lock/addr/wdata from requesters; gnt/rvalid/rdata/err/err_src back.
interface mem_port_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic [2:0]      req;      // per-port request, held until granted
    logic [2:0]      we;       // per-port write enable
    logic [2:0]      lock;     // per-port burst lock
    logic [3*AW-1:0] addr;     // port i at [i*AW +: AW]
    logic [3*DW-1:0] wdata;    // port i at [i*DW +: DW]
    logic [2:0]      gnt;      // one-hot grant, same cycle as the access
    logic [2:0]      rvalid;   // one-hot read-data valid, one cycle later
    logic [DW-1:0]   rdata;    // shared read data
    logic            err;      // one-cycle starvation pulse
    logic [2:0]      err_src;  // sticky starved-port record

    modport master (
        output req, we, lock, addr, wdata,
        input  gnt, rvalid, rdata, err, err_src
    );

    modport slave (
        input  req, we, lock, addr, wdata,
        output gnt, rvalid, rdata, err, err_src
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one synchronous single-port RAM between loader (0), fetch (1) and write-back (2).
// Latency: grant and RAM access in the request cycle; read data/rvalid one cycle later.
// Backpressure: losers hold req until granted; a locked owner is never preempted.
// Ports: clk, rstn (async active-low); bus (slave side of mem_port_arbiter_if);
//        mem_en_o/mem_we_o/mem_addr_o/mem_wdata_o to the RAM, mem_rdata_i from it.
module mem_port_arbiter #(
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int MAXWAIT = 15
) (
    input  logic              clk,
    input  logic              rstn,
    mem_port_arbiter_if.slave bus,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [AW-1:0]     mem_addr_o,
    output logic [DW-1:0]     mem_wdata_o,
    input  logic [DW-1:0]     mem_rdata_i
);
    localparam int            CW       = (MAXWAIT < 1) ? 1 : $clog2(MAXWAIT + 1);
    localparam logic [CW-1:0] WAIT_MAX = CW'(MAXWAIT);

    typedef enum logic [1:0] {OWN_NONE, OWN_P0, OWN_P1, OWN_P2} owner_e;

    owner_e        owner_q, owner_d;
    logic          last_rr_q, last_rr_d;   // 0: port 1 won last tie-break, 1: port 2
    logic [2:0]    rvalid_q, rvalid_d;
    logic [CW-1:0] wait_q [3];
    logic [CW-1:0] wait_d [3];
    logic          err_q, err_d;
    logic [2:0]    err_src_q, err_src_d;
    logic [2:0]    gnt;
    logic [2:0]    hit;
    logic [1:0]    own_idx;
    logic          own_vld;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            owner_q   <= OWN_NONE;
            last_rr_q <= 1'b1;            // port 1 wins the first 1/2 tie
            rvalid_q  <= '0;
            err_q     <= 1'b0;
            err_src_q <= '0;
            for (int i = 0; i < 3; i++) wait_q[i] <= '0;
        end else begin
            owner_q   <= owner_d;
            last_rr_q <= last_rr_d;
            rvalid_q  <= rvalid_d;
            err_q     <= err_d;
            err_src_q <= err_src_d;
            for (int i = 0; i < 3; i++) wait_q[i] <= wait_d[i];
        end
    end

    always_comb begin
        own_idx     = 2'd0;
        own_vld     = 1'b0;
        gnt         = '0;
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        owner_d     = OWN_NONE;
        last_rr_d   = last_rr_q;
        hit         = '0;

        case (owner_q)
            OWN_P0:  begin own_idx = 2'd0; own_vld = 1'b1; end
            OWN_P1:  begin own_idx = 2'd1; own_vld = 1'b1; end
            OWN_P2:  begin own_idx = 2'd2; own_vld = 1'b1; end
            default: ;
        endcase

        // A live owner keeps the port; if it dropped req the lock is released
        // and the same cycle falls through to normal arbitration.
        if (own_vld && bus.req[own_idx])         gnt[own_idx] = 1'b1;
        else if (bus.req[0])                     gnt = 3'b001;
        else if (bus.req[1] && bus.req[2])       gnt = last_rr_q ? 3'b010 : 3'b100;
        else if (bus.req[1])                     gnt = 3'b010;
        else if (bus.req[2])                     gnt = 3'b100;

        for (int i = 0; i < 3; i++) begin
            if (gnt[i]) begin
                mem_en_o    = 1'b1;
                mem_we_o    = bus.we[i];
                mem_addr_o  = bus.addr[i*AW +: AW];
                mem_wdata_o = bus.wdata[i*DW +: DW];
                if (bus.lock[i])
                    owner_d = (i == 0) ? OWN_P0 : ((i == 1) ? OWN_P1 : OWN_P2);
                if (i == 1) last_rr_d = 1'b0;
                if (i == 2) last_rr_d = 1'b1;
            end
        end

        rvalid_d = gnt & ~bus.we;

        // Saturating wait counters; the pulse fires only on the step into MAXWAIT.
        for (int i = 0; i < 3; i++) begin
            wait_d[i] = wait_q[i];
            if (!bus.req[i] || gnt[i]) begin
                wait_d[i] = '0;
            end else if (wait_q[i] != WAIT_MAX) begin
                wait_d[i] = wait_q[i] + 1'b1;
                hit[i]    = (wait_d[i] == WAIT_MAX);
            end
        end

        err_d     = |hit;
        err_src_d = err_src_q | hit;
    end

    assign bus.gnt     = gnt;
    assign bus.rvalid  = rvalid_q;
    assign bus.rdata   = mem_rdata_i;
    assign bus.err     = err_q;
    assign bus.err_src = err_src_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose: self-checking bench for mem_port_arbiter against a rule-level model.
// Latency: checks grant/RAM strobes in-cycle, rvalid/rdata/err one cycle later.
// Backpressure: none modelled beyond the arbiter's own grant rules.
module tb_mem_port_arbiter;
    localparam int AW      = 8;
    localparam int DW      = 8;
    localparam int MAXWAIT = 15;

    logic          clk  = 1'b0;
    logic          rstn = 1'b0;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] ram [256];

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_port_arbiter #(.AW(AW), .DW(DW), .MAXWAIT(MAXWAIT)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .bus         (bus.slave),
        .mem_en_o    (mem_en),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata)
    );

    // Synchronous single-port RAM driven only by the arbiter.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    // Reference model state
    int            m_owner;      // -1 = nobody holds a lock
    int            m_last_rr;    // 1 or 2
    int            m_wait [3];
    logic [2:0]    m_rvalid;
    logic [DW-1:0] m_rdata;
    logic          m_err;
    logic [2:0]    m_err_src;
    logic [DW-1:0] shadow [256];

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner   = -1;
        m_last_rr = 2;
        for (int i = 0; i < 3; i++) m_wait[i] = 0;
        m_rvalid  = '0;
        m_err     = 1'b0;
        m_err_src = '0;
    endtask

    function automatic int ref_grant(input logic [2:0] r);
        if (m_owner >= 0 && r[m_owner]) return m_owner;
        if (r[0]) return 0;
        if (r[1] && r[2]) return (m_last_rr == 1) ? 2 : 1;
        if (r[1]) return 1;
        if (r[2]) return 2;
        return -1;
    endfunction

    // One clock cycle: drive, check combinational outputs, clock, check registered outputs.
    task automatic cycle(input logic [2:0] r, input logic [2:0] w, input logic [2:0] l,
                         input logic [3*AW-1:0] a, input logic [3*DW-1:0] d,
                         output logic [2:0] seen);
        int g;
        logic [2:0] g_oh;
        bus.req = r; bus.we = w; bus.lock = l; bus.addr = a; bus.wdata = d;
        #2;
        g    = ref_grant(r);
        g_oh = (g < 0) ? 3'b000 : 3'(1 << g);
        seen = bus.gnt;
        chk("gnt", 32'(bus.gnt), 32'(g_oh));
        chk("mem_en", 32'(mem_en), 32'(g >= 0));
        if (g >= 0) begin
            chk("mem_we",    32'(mem_we),    32'(w[g]));
            chk("mem_addr",  32'(mem_addr),  32'(a[g*AW +: AW]));
            chk("mem_wdata", 32'(mem_wdata), 32'(d[g*DW +: DW]));
        end else begin
            chk("idle_we",    32'(mem_we),    32'd0);
            chk("idle_addr",  32'(mem_addr),  32'd0);
            chk("idle_wdata", 32'(mem_wdata), 32'd0);
        end
        @(posedge clk);
        #1;
        m_rvalid = '0;
        m_err    = 1'b0;
        if (g >= 0 && !w[g]) begin
            m_rvalid[g] = 1'b1;
            m_rdata     = shadow[a[g*AW +: AW]];
        end
        if (g >= 0 && w[g]) shadow[a[g*AW +: AW]] = d[g*DW +: DW];
        m_owner = (g >= 0 && l[g]) ? g : -1;
        if (g == 1 || g == 2) m_last_rr = g;
        for (int i = 0; i < 3; i++) begin
            if (!r[i] || g == i) m_wait[i] = 0;
            else if (m_wait[i] < MAXWAIT) begin
                m_wait[i]++;
                if (m_wait[i] == MAXWAIT) begin
                    m_err        = 1'b1;
                    m_err_src[i] = 1'b1;
                end
            end
        end
        chk("rvalid",  32'(bus.rvalid),  32'(m_rvalid));
        chk("err",     32'(bus.err),     32'(m_err));
        chk("err_src", 32'(bus.err_src), 32'(m_err_src));
        if (m_rvalid != 3'b000) chk("rdata", 32'(bus.rdata), 32'(m_rdata));
    endtask

    task automatic idle_inputs();
        bus.req = '0; bus.we = '0; bus.lock = '0; bus.addr = '0; bus.wdata = '0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        idle_inputs();
        #1;
        model_reset();
        chk("rst_rvalid",  32'(bus.rvalid),  32'd0);
        chk("rst_err",     32'(bus.err),     32'd0);
        chk("rst_err_src", 32'(bus.err_src), 32'd0);
        chk("rst_gnt",     32'(bus.gnt),     32'd0);
        chk("rst_mem_en",  32'(mem_en),      32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0]      seen;
        logic [DW-1:0]   v;
        int              pulses;

        // Reset state
        idle_inputs();
        model_reset();
        #1;
        chk("rst_gnt",     32'(bus.gnt),     32'd0);
        chk("rst_mem_en",  32'(mem_en),      32'd0);
        chk("rst_mem_we",  32'(mem_we),      32'd0);
        chk("rst_addr",    32'(mem_addr),    32'd0);
        chk("rst_wdata",   32'(mem_wdata),   32'd0);
        chk("rst_rvalid",  32'(bus.rvalid),  32'd0);
        chk("rst_err",     32'(bus.err),     32'd0);
        chk("rst_err_src", 32'(bus.err_src), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Preload the whole RAM through the loader port
        for (int a = 0; a < 256; a++) begin
            v = (a == 'h10) ? 8'hA5 : 8'($urandom);
            cycle(3'b001, 3'b001, 3'b000, {16'h0, 8'(a)}, {16'h0, v}, seen);
        end

        // Round-robin between ports 1 and 2 right after reset
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cycle(3'b110, 3'b000, 3'b000, 24'($urandom), 24'($urandom), seen);
            chk("rr_gnt", 32'(seen), (i % 2 == 0) ? 32'h2 : 32'h4);
            chk("rr_err", 32'(bus.err), 32'd0);
        end

        // Single read of 0x10
        cycle(3'b010, 3'b000, 3'b000, {8'h0, 8'h10, 8'h0}, 24'h0, seen);
        chk("rd_gnt",    32'(seen),       32'h2);
        chk("rd_rvalid", 32'(bus.rvalid), 32'h2);
        chk("rd_data",   32'(bus.rdata),  32'hA5);

        // Locked 4-word burst on port 1 with port 0 competing from the 2nd cycle
        for (int i = 0; i < 5; i++) begin
            if (i < 4) cycle((i == 0) ? 3'b010 : 3'b011, 3'b000, 3'b010,
                             {8'h0, 8'(8'h20 + i), 8'h77}, 24'h0, seen);
            else       cycle(3'b001, 3'b000, 3'b000, {16'h0, 8'h77}, 24'h0, seen);
            chk("burst_gnt", 32'(seen), (i < 4) ? 32'h2 : 32'h1);
        end

        // Loader priority starves ports 1 and 2
        do_reset();
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(3'b111, 3'b000, 3'b000, 24'($urandom), 24'($urandom), seen);
            chk("ldr_gnt", 32'(seen), 32'h1);
            if (bus.err) pulses++;
        end
        chk("ldr_pulses",  32'(pulses),      32'd1);
        chk("ldr_err_src", 32'(bus.err_src), 32'h6);
        for (int i = 0; i < 3; i++)
            cycle(3'b000, 3'b000, 3'b000, 24'h0, 24'h0, seen);
        chk("ldr_sticky", 32'(bus.err_src), 32'h6);

        // Write from port 2 then read back on port 1
        cycle(3'b100, 3'b100, 3'b000, {8'h05, 16'h0}, {8'h3C, 16'h0}, seen);
        chk("wr_gnt",    32'(seen),       32'h4);
        chk("wr_rvalid", 32'(bus.rvalid), 32'd0);
        cycle(3'b010, 3'b000, 3'b000, {8'h0, 8'h05, 8'h0}, 24'h0, seen);
        chk("wrrd_rvalid", 32'(bus.rvalid), 32'h2);
        chk("wrrd_data",   32'(bus.rdata),  32'h3C);

        // Reset during a locked read: rvalid drops at once, lock and tie state cleared
        cycle(3'b100, 3'b000, 3'b100, 24'($urandom), 24'h0, seen);
        chk("pre_rst_rvalid", 32'(bus.rvalid), 32'h4);
        do_reset();
        cycle(3'b110, 3'b000, 3'b000, 24'($urandom), 24'h0, seen);
        chk("post_rst_gnt", 32'(seen), 32'h2);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            cycle(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000,
                  24'($urandom), 24'($urandom), seen);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
